imm_gen_stage: RTL and testbench

Registered, handshaked immediate generator for the ID stage. Decodes all RV32I/RV64I immediate formats (R, I, S, B, U, J) from a 32-bit instruction and sign-extends to a parametrised width. A 2-entry skid buffer gives full throughput under back-pressure, with a synchronous flush for branch mispredicts. Sits between the IF/ID register and the register-read/ALU operand mux.

---
 rtl/imm_gen_pkg.sv | 39 +++
 rtl/imm_decode.sv | 70 +++++++
 rtl/imm_gen_stage.sv | 96 +++++++++
 tb/tb_imm_gen_stage.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/imm_gen_pkg.sv
// Shared types for the ID-stage immediate generator.
//   - RV32I/RV64I major opcodes used by the decoder
//   - fmt_e   : immediate format code presented on o_fmt
//   - entry_t : one skid-buffer entry (instruction + decoded immediate)
// Build option: IMM_BRANCH_SHL_EN (see imm_decode.sv).
package imm_gen_pkg;

  localparam logic [6:0] LD         = 7'b0000011;
  localparam logic [6:0] SD         = 7'b0100011;
  localparam logic [6:0] BRANCH     = 7'b1100011;
  localparam logic [6:0] ALU_IMM    = 7'b0010011;
  localparam logic [6:0] ALU_IMM_32 = 7'b0011011;
  localparam logic [6:0] ALU        = 7'b0110011;
  localparam logic [6:0] ALU_32     = 7'b0111011;
  localparam logic [6:0] JALR       = 7'b1100111;
  localparam logic [6:0] JAL        = 7'b1101111;
  localparam logic [6:0] LUI        = 7'b0110111;
  localparam logic [6:0] AUIPC      = 7'b0010111;

  typedef enum logic [2:0] {
    FMT_R   = 3'd0,
    FMT_I   = 3'd1,
    FMT_S   = 3'd2,
    FMT_B   = 3'd3,
    FMT_U   = 3'd4,
    FMT_J   = 3'd5,
    FMT_ILL = 3'd7
  } fmt_e;

  // Every immediate is a sign extension of inst[31] and fits in 32 bits,
  // so entries hold the 32-bit form; the top widens it to ADDR_W on output.
  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] imm;
    fmt_e        fmt;
    logic        illegal;
  } entry_t;

endpackage

// File: rtl/imm_decode.sv
// Pure combinational immediate decoder: inst -> {imm, fmt, illegal}.
// Ports:
//   i_inst    32-bit instruction word
//   o_imm     sign-extended immediate, ADDR_W bits
//   o_fmt     format code (fmt_e)
//   o_illegal opcode not recognised (imm forced to 0)
// Build option IMM_BRANCH_SHL_EN: B/J immediates emitted as byte offsets
// (field << 1); otherwise raw half-word offsets for the post-mux shifter.
module imm_decode
  import imm_gen_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic [31:0]       i_inst,
  output logic [ADDR_W-1:0] o_imm,
  output fmt_e              o_fmt,
  output logic              o_illegal
);

  logic [31:0] w_imm32;
  logic        w_s;

  assign w_s = i_inst[31];

  always_comb begin
    w_imm32   = '0;
    o_fmt     = FMT_ILL;
    o_illegal = 1'b0;
    case (i_inst[6:0])
      LD, ALU_IMM, ALU_IMM_32, JALR: begin
        o_fmt   = FMT_I;
        w_imm32 = {{20{w_s}}, i_inst[31:20]};
      end
      SD: begin
        o_fmt   = FMT_S;
        w_imm32 = {{20{w_s}}, i_inst[31:25], i_inst[11:7]};
      end
      BRANCH: begin
        o_fmt = FMT_B;
`ifdef IMM_BRANCH_SHL_EN
        w_imm32 = {{19{w_s}}, w_s, i_inst[7], i_inst[30:25], i_inst[11:8], 1'b0};
`else
        w_imm32 = {{20{w_s}}, w_s, i_inst[7], i_inst[30:25], i_inst[11:8]};
`endif
      end
      LUI, AUIPC: begin
        o_fmt   = FMT_U;
        w_imm32 = {i_inst[31:12], 12'b0};
      end
      JAL: begin
        o_fmt = FMT_J;
`ifdef IMM_BRANCH_SHL_EN
        w_imm32 = {{11{w_s}}, w_s, i_inst[19:12], i_inst[20], i_inst[30:21], 1'b0};
`else
        w_imm32 = {{12{w_s}}, w_s, i_inst[19:12], i_inst[20], i_inst[30:21]};
`endif
      end
      ALU, ALU_32: begin
        o_fmt = FMT_R;
      end
      default: begin
        o_fmt     = FMT_ILL;
        o_illegal = 1'b1;
      end
    endcase
  end

  assign o_imm = ADDR_W'($signed(w_imm32));

endmodule

// File: rtl/imm_gen_stage.sv
// Registered, handshaked immediate generator for the ID stage.
// Decodes i_inst combinationally, captures the result on accept into a
// 2-entry skid buffer (main drives outputs, skid absorbs one beat of
// back-pressure) so the stage keeps full throughput.
// Ports:
//   i_clk, i_rst (async, active high), i_flush (sync, highest priority)
//   i_valid/o_ready/i_inst          upstream handshake
//   o_valid/i_ready                 downstream handshake
//   o_inst, o_imm, o_fmt, o_illegal decoded entry
// Build option IMM_BRANCH_SHL_EN: forwarded to imm_decode.
module imm_gen_stage
  import imm_gen_pkg::*;
#(
  parameter int INST_W = 32,
  parameter int ADDR_W = 64
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_flush,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [INST_W-1:0] i_inst,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [INST_W-1:0] o_inst,
  output logic [ADDR_W-1:0] o_imm,
  output fmt_e              o_fmt,
  output logic              o_illegal
);

  if (INST_W != 32) begin : g_bad_inst_w
    $error("imm_gen_stage: INST_W must be 32");
  end
  if (ADDR_W < 32) begin : g_bad_addr_w
    $error("imm_gen_stage: ADDR_W must be >= 32");
  end

  entry_t      r_main, r_skid;
  logic        r_main_v, r_skid_v;
  entry_t      w_new;
  logic [31:0] w_imm32;
  fmt_e        w_fmt;
  logic        w_ill;
  logic        w_acc, w_xfer;

  // Decoded at 32 bits; widening happens once, at the output.
  imm_decode #(.ADDR_W(32)) u_dec (
    .i_inst    (i_inst[31:0]),
    .o_imm     (w_imm32),
    .o_fmt     (w_fmt),
    .o_illegal (w_ill)
  );

  assign w_new = '{inst: i_inst[31:0], imm: w_imm32, fmt: w_fmt, illegal: w_ill};

  // o_ready is a pure register: no path from i_ready.
  assign o_ready = !r_skid_v;
  assign w_acc   = i_valid && o_ready;
  assign w_xfer  = r_main_v && i_ready;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_main_v <= 1'b0;
      r_skid_v <= 1'b0;
      r_main   <= '0;
      r_skid   <= '0;
    end else if (i_flush) begin
      r_main_v <= 1'b0;
      r_skid_v <= 1'b0;
    end else if (w_xfer) begin
      if (r_skid_v) begin
        // Skid full implies no accept this cycle; promote skid to main.
        r_main   <= r_skid;
        r_skid_v <= 1'b0;
      end else begin
        r_main_v <= w_acc;
        if (w_acc) r_main <= w_new;
      end
    end else if (w_acc) begin
      if (!r_main_v) begin
        r_main   <= w_new;
        r_main_v <= 1'b1;
      end else begin
        r_skid   <= w_new;
        r_skid_v <= 1'b1;
      end
    end
  end

  assign o_valid   = r_main_v;
  assign o_inst    = r_main.inst;
  assign o_imm     = ADDR_W'($signed(r_main.imm));
  assign o_fmt     = r_main.fmt;
  assign o_illegal = r_main.illegal;

endmodule

// File: tb/tb_imm_gen_stage.sv
module tb_imm_gen_stage;
  import imm_gen_pkg::*;

  logic        i_clk = 1'b0;
  logic        i_rst, i_flush, i_valid, i_ready;
  logic [31:0] i_inst;
  logic        o_ready, o_valid, o_illegal;
  logic [31:0] o_inst;
  logic [63:0] o_imm;
  fmt_e        o_fmt;
  // narrow instance for ADDR_W=32 checks
  logic        n_ready, n_valid, n_illegal;
  logic [31:0] n_inst, n_imm;
  fmt_e        n_fmt;

  int checks = 0;
  int errors = 0;

  always #5 i_clk = ~i_clk;

  imm_gen_stage #(.INST_W(32), .ADDR_W(64)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_flush(i_flush), .i_valid(i_valid),
    .o_ready(o_ready), .i_inst(i_inst), .o_valid(o_valid), .i_ready(i_ready),
    .o_inst(o_inst), .o_imm(o_imm), .o_fmt(o_fmt), .o_illegal(o_illegal));

  imm_gen_stage #(.INST_W(32), .ADDR_W(32)) dut32 (
    .i_clk(i_clk), .i_rst(i_rst), .i_flush(i_flush), .i_valid(i_valid),
    .o_ready(n_ready), .i_inst(i_inst), .o_valid(n_valid), .i_ready(i_ready),
    .o_inst(n_inst), .o_imm(n_imm), .o_fmt(n_fmt), .o_illegal(n_illegal));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // advance one rising edge, then sample 1 time unit later
  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  initial begin
    i_rst = 1'b1; i_flush = 1'b0; i_valid = 1'b0; i_ready = 1'b1; i_inst = '0;
    #3;
    chk("rst_valid",   64'(o_valid), 64'd0);
    chk("rst_ready",   64'(o_ready), 64'd1);
    chk("rst_inst",    64'(o_inst), 64'd0);
    chk("rst_imm",     o_imm, 64'd0);
    chk("rst_fmt",     64'(o_fmt), 64'(FMT_R));
    chk("rst_illegal", 64'(o_illegal), 64'd0);
    step();
    i_rst = 1'b0;

    // ld x1,-8(x2)
    i_valid = 1'b1; i_inst = 32'hFF813083;
    step();
    chk("ld_valid", 64'(o_valid), 64'd1);
    chk("ld_imm",   o_imm, 64'hFFFFFFFFFFFFFFF8);
    chk("ld_fmt",   64'(o_fmt), 64'(FMT_I));
    chk("ld_inst",  64'(o_inst), 64'hFF813083);
    // sd x1,16(x2)
    i_inst = 32'h00113823;
    step();
    chk("sd_imm", o_imm, 64'h0000000000000010);
    chk("sd_fmt", 64'(o_fmt), 64'(FMT_S));
    // beq x0,x0,-4
    i_inst = 32'hFE000EE3;
    step();
    chk("beq_fmt", 64'(o_fmt), 64'(FMT_B));
`ifdef IMM_BRANCH_SHL_EN
    chk("beq_imm", o_imm, 64'hFFFFFFFFFFFFFFFC);
`else
    chk("beq_imm", o_imm, 64'hFFFFFFFFFFFFFFFE);
`endif
    // jal x0,-4
    i_inst = 32'hFFDFF06F;
    step();
    chk("jal_fmt", 64'(o_fmt), 64'(FMT_J));
`ifdef IMM_BRANCH_SHL_EN
    chk("jal_imm", o_imm, 64'hFFFFFFFFFFFFFFFC);
`else
    chk("jal_imm", o_imm, 64'hFFFFFFFFFFFFFFFE);
`endif
    // lui x5,0x12345
    i_inst = 32'h123452B7;
    step();
    chk("lui_pos_imm", o_imm, 64'h0000000012345000);
    chk("lui_pos_fmt", 64'(o_fmt), 64'(FMT_U));
    // lui x5,0x80000
    i_inst = 32'h800002B7;
    step();
    chk("lui_neg_imm",   o_imm, 64'hFFFFFFFF80000000);
    chk("lui_neg_imm32", 64'(n_imm), 64'h0000000080000000);
    // add (R format)
    i_inst = 32'h002081B3;
    step();
    chk("add_fmt", 64'(o_fmt), 64'(FMT_R));
    chk("add_imm", o_imm, 64'd0);
    chk("add_ill", 64'(o_illegal), 64'd0);
    // unknown opcode
    i_inst = 32'h0000007F;
    step();
    chk("ill_flag", 64'(o_illegal), 64'd1);
    chk("ill_fmt",  64'(o_fmt), 64'(FMT_ILL));
    chk("ill_imm",  o_imm, 64'd0);
    i_valid = 1'b0;
    step();
    chk("drain_valid", 64'(o_valid), 64'd0);

    // back-pressure: three addi, downstream stalled for 3 cycles
    i_ready = 1'b0; i_valid = 1'b1; i_inst = 32'h00100093;
    step();
    chk("bp1_valid", 64'(o_valid), 64'd1);
    chk("bp1_imm",   o_imm, 64'd1);
    chk("bp1_ready", 64'(o_ready), 64'd1);
    i_inst = 32'h00200093;
    step();
    chk("bp2_ready", 64'(o_ready), 64'd0);
    chk("bp2_imm",   o_imm, 64'd1);
    i_inst = 32'h00300093;
    step();
    chk("bp3_ready", 64'(o_ready), 64'd0);
    chk("bp3_imm",   o_imm, 64'd1);
    i_ready = 1'b1;
    step();
    chk("bp4_imm",   o_imm, 64'd2);
    chk("bp4_ready", 64'(o_ready), 64'd1);
    step();
    chk("bp5_imm",   o_imm, 64'd3);
    chk("bp5_valid", 64'(o_valid), 64'd1);
    i_valid = 1'b0;
    step();
    chk("bp6_valid", 64'(o_valid), 64'd0);

    // flush with skid full and an incoming instruction
    i_ready = 1'b0; i_valid = 1'b1; i_inst = 32'h00100093;
    step();
    i_inst = 32'h00200093;
    step();
    chk("fl_full_ready", 64'(o_ready), 64'd0);
    i_flush = 1'b1; i_inst = 32'h00500093;
    step();
    chk("fl_valid", 64'(o_valid), 64'd0);
    chk("fl_ready", 64'(o_ready), 64'd1);
    i_flush = 1'b0; i_valid = 1'b0; i_ready = 1'b1;
    step();
    chk("fl_after_valid", 64'(o_valid), 64'd0);

    // asynchronous reset while holding a valid entry
    i_ready = 1'b0; i_valid = 1'b1; i_inst = 32'h00700093;
    step();
    chk("ar_pre_valid", 64'(o_valid), 64'd1);
    i_valid = 1'b0;
    #2 i_rst = 1'b1;
    #1;
    chk("ar_valid", 64'(o_valid), 64'd0);
    chk("ar_imm",   o_imm, 64'd0);
    chk("ar_ready", 64'(o_ready), 64'd1);
    step();
    i_rst = 1'b0;
    step();
    chk("ar_post_valid", 64'(o_valid), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
